// File: rtl/pulse_count_run_ctrl.sv
// Run sequencer for the diff-trigger pulse counter: arms the counter, collects
// per-window results onto a valid/ready port and keeps saturating run totals.
module pulse_count_run_ctrl #(
    parameter int COUNTER_WIDTH = 16,
    parameter int TOTAL_WIDTH   = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [15:0]              cfg_window_cycles,
    input  logic [15:0]              cfg_num_windows,
    output logic                     cnt_enable,
    output logic [15:0]              cnt_window_cycles,
    input  logic                     cnt_count_valid,
    input  logic [COUNTER_WIDTH-1:0] cnt_pulse_count,
    input  logic [COUNTER_WIDTH-1:0] cnt_pileup_count,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_index,
    output logic [COUNTER_WIDTH-1:0] res_pulse,
    output logic [COUNTER_WIDTH-1:0] res_pileup,
    output logic [TOTAL_WIDTH-1:0]   total_pulse,
    output logic [TOTAL_WIDTH-1:0]   total_pileup,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     overrun,
    output logic                     sat,
    output logic                     cfg_err
);

    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [15:0]            num_windows;
    logic [15:0]            win_cnt;
    logic [SW-1:0]          settle_cnt;
    logic [TOTAL_WIDTH:0]   pulse_sum;
    logic [TOTAL_WIDTH:0]   pileup_sum;
    logic                   capture;
    logic                   accept;
    logic                   last_window;

    // MSB of the result flags that the total clamped at all-ones.
    function automatic logic [TOTAL_WIDTH:0] sat_add(
        input logic [TOTAL_WIDTH-1:0]   acc,
        input logic [COUNTER_WIDTH-1:0] inc
    );
        logic [TOTAL_WIDTH:0] s;
        s = {1'b0, acc} + (TOTAL_WIDTH + 1)'(inc);
        if (s[TOTAL_WIDTH])
            s = {1'b1, {TOTAL_WIDTH{1'b1}}};
        return s;
    endfunction

    assign capture     = (state == S_RUN) && cnt_count_valid;
    assign accept      = res_valid && res_ready;
    assign last_window = (win_cnt == num_windows - 16'd1);
    assign pulse_sum   = sat_add(total_pulse, cnt_pulse_count);
    assign pileup_sum  = sat_add(total_pileup, cnt_pileup_count);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            num_windows       <= '0;
            win_cnt           <= '0;
            settle_cnt        <= '0;
            cnt_enable        <= 1'b0;
            cnt_window_cycles <= '0;
            res_valid         <= 1'b0;
            res_index         <= '0;
            res_pulse         <= '0;
            res_pileup        <= '0;
            total_pulse       <= '0;
            total_pileup      <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            aborted           <= 1'b0;
            overrun           <= 1'b0;
            sat               <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;

            // A landing result wins over a same-cycle accept; it only counts
            // as an overrun when the previous one is still unread.
            if (capture) begin
                res_pulse    <= cnt_pulse_count;
                res_pileup   <= cnt_pileup_count;
                res_index    <= win_cnt;
                res_valid    <= 1'b1;
                total_pulse  <= pulse_sum[TOTAL_WIDTH-1:0];
                total_pileup <= pileup_sum[TOTAL_WIDTH-1:0];
                win_cnt      <= win_cnt + 16'd1;
                if (pulse_sum[TOTAL_WIDTH] || pileup_sum[TOTAL_WIDTH])
                    sat <= 1'b1;
                if (res_valid && !res_ready)
                    overrun <= 1'b1;
            end else if (accept) begin
                res_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_window_cycles != 16'd0 && cfg_num_windows != 16'd0) begin
                            cnt_window_cycles <= cfg_window_cycles;
                            num_windows       <= cfg_num_windows;
                            total_pulse       <= '0;
                            total_pileup      <= '0;
                            win_cnt           <= '0;
                            aborted           <= 1'b0;
                            overrun           <= 1'b0;
                            sat               <= 1'b0;
                            busy              <= 1'b1;
                            state             <= S_ARM;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        aborted    <= 1'b1;
                        settle_cnt <= '0;
                        state      <= S_DRAIN;
                    end else begin
                        cnt_enable <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort || (capture && last_window)) begin
                        cnt_enable <= 1'b0;
                        settle_cnt <= '0;
                        state      <= S_DRAIN;
                        if (abort)
                            aborted <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Let the counter pipeline flush, then wait for the last result to be read.
                    if (settle_cnt != SW'(SETTLE_CYCLES)) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else if (!res_valid) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_count_run_ctrl.sv
// Scoreboard bench for pulse_count_run_ctrl; a second instance with 16-bit
// totals exercises run-total saturation on the same stimulus.
module tb_pulse_count_run_ctrl;

    localparam int CW     = 16;
    localparam int TW     = 32;
    localparam int TW16   = 16;
    localparam int SETTLE = 4;

    typedef struct packed {
        logic [15:0] idx;
        logic [15:0] p;
        logic [15:0] pu;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [15:0]    cfg_window_cycles;
    logic [15:0]    cfg_num_windows;
    logic           cnt_count_valid;
    logic [CW-1:0]  cnt_pulse_count;
    logic [CW-1:0]  cnt_pileup_count;
    logic           res_ready;

    logic           cnt_enable, res_valid, busy, done, aborted, overrun, sat, cfg_err;
    logic [15:0]    cnt_window_cycles, res_index;
    logic [CW-1:0]  res_pulse, res_pileup;
    logic [TW-1:0]  total_pulse, total_pileup;

    logic           s_cnt_enable, s_res_valid, s_busy, s_done, s_aborted, s_overrun, s_sat, s_cfg_err;
    logic [15:0]    s_cnt_window_cycles, s_res_index;
    logic [CW-1:0]  s_res_pulse, s_res_pileup;
    logic [TW16-1:0] s_total_pulse, s_total_pileup;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk;
    int   n_pass;
    int   done_cnt;
    int   n;

    pulse_count_run_ctrl #(.COUNTER_WIDTH(CW), .TOTAL_WIDTH(TW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_window_cycles(cfg_window_cycles), .cfg_num_windows(cfg_num_windows),
        .cnt_enable(cnt_enable), .cnt_window_cycles(cnt_window_cycles),
        .cnt_count_valid(cnt_count_valid), .cnt_pulse_count(cnt_pulse_count),
        .cnt_pileup_count(cnt_pileup_count), .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .res_pulse(res_pulse), .res_pileup(res_pileup),
        .total_pulse(total_pulse), .total_pileup(total_pileup), .busy(busy), .done(done),
        .aborted(aborted), .overrun(overrun), .sat(sat), .cfg_err(cfg_err)
    );

    pulse_count_run_ctrl #(.COUNTER_WIDTH(CW), .TOTAL_WIDTH(TW16), .SETTLE_CYCLES(SETTLE)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_window_cycles(cfg_window_cycles), .cfg_num_windows(cfg_num_windows),
        .cnt_enable(s_cnt_enable), .cnt_window_cycles(s_cnt_window_cycles),
        .cnt_count_valid(cnt_count_valid), .cnt_pulse_count(cnt_pulse_count),
        .cnt_pileup_count(cnt_pileup_count), .res_valid(s_res_valid), .res_ready(res_ready),
        .res_index(s_res_index), .res_pulse(s_res_pulse), .res_pileup(s_res_pileup),
        .total_pulse(s_total_pulse), .total_pileup(s_total_pileup), .busy(s_busy), .done(s_done),
        .aborted(s_aborted), .overrun(s_overrun), .sat(s_sat), .cfg_err(s_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input logic [15:0] w, input logic [15:0] nw);
        cfg_window_cycles = w;
        cfg_num_windows   = nw;
        start             = 1'b1;
        tick();
        start             = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] idx, input logic [15:0] p,
                          input logic [15:0] pu, input bit ovw);
        exp_t e;
        e.idx = idx;
        e.p   = p;
        e.pu  = pu;
        if (ovw && q.size() > 0)
            void'(q.pop_back());
        q.push_back(e);
        cnt_count_valid  = 1'b1;
        cnt_pulse_count  = p;
        cnt_pileup_count = pu;
        tick();
        cnt_count_valid  = 1'b0;
        cnt_pulse_count  = '0;
        cnt_pileup_count = '0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        tick();
    endtask

    // Scoreboard side: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1)
            done_cnt++;
        if (rst_n && res_valid && res_ready) begin
            if (q.size() == 0) begin
                chk("res_unexpected", 32'(res_index), 32'hFFFF_FFFF);
            end else begin
                mon_e = q.pop_front();
                chk("res_index", 32'(res_index), 32'(mon_e.idx));
                chk("res_pulse", 32'(res_pulse), 32'(mon_e.p));
                chk("res_pileup", 32'(res_pileup), 32'(mon_e.pu));
                chk("res16_pulse", 32'(s_res_pulse), 32'(mon_e.p));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_window_cycles = '0; cfg_num_windows = '0;
        cnt_count_valid = 1'b0; cnt_pulse_count = '0; cnt_pileup_count = '0;
        res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_cnt_enable", 32'(cnt_enable), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_total_pulse", total_pulse, 0);
        chk("rst_win_cycles", 32'(cnt_window_cycles), 0);
        rst_n = 1'b1;
        tick();

        // T1: three windows, consumer always ready
        done_cnt = 0;
        run_start(16'd10, 16'd3);
        chk("t1_busy_arm", 32'(busy), 1);
        chk("t1_en_arm", 32'(cnt_enable), 0);
        tick();
        chk("t1_en_run", 32'(cnt_enable), 1);
        chk("t1_win_cycles", 32'(cnt_window_cycles), 10);
        strobe(16'd0, 16'd5, 16'd1, 1'b0); tick();
        strobe(16'd1, 16'd7, 16'd2, 1'b0); tick();
        strobe(16'd2, 16'd9, 16'd0, 1'b0);
        chk("t1_en_off", 32'(cnt_enable), 0);
        wait_done(n);
        chk("t1_total_pulse", total_pulse, 21);
        chk("t1_total_pileup", total_pileup, 3);
        chk("t1_done_once", done_cnt, 1);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_queue_empty", q.size(), 0);
        chk("t1_overrun", 32'(overrun), 0);

        // T2: consumer stalled across both strobes
        done_cnt = 0;
        res_ready = 1'b0;
        run_start(16'd4, 16'd2);
        tick();
        strobe(16'd0, 16'd4, 16'd0, 1'b0); tick();
        strobe(16'd1, 16'd6, 16'd1, 1'b1);
        chk("t2_res_pulse", 32'(res_pulse), 6);
        chk("t2_res_index", 32'(res_index), 1);
        chk("t2_overrun", 32'(overrun), 1);
        repeat (10) tick();
        chk("t2_busy_wait", 32'(busy), 1);
        chk("t2_no_done_yet", done_cnt, 0);
        res_ready = 1'b1;
        wait_done(n);
        chk("t2_done_once", done_cnt, 1);
        chk("t2_queue_empty", q.size(), 0);

        // T3: abort after first result
        done_cnt = 0;
        run_start(16'd7, 16'd5);
        tick();
        strobe(16'd0, 16'd8, 16'd2, 1'b0); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_en_off", 32'(cnt_enable), 0);
        chk("t3_aborted", 32'(aborted), 1);
        wait_done(n);
        chk("t3_done_latency", n, SETTLE + 1);
        chk("t3_total_pulse", total_pulse, 8);
        chk("t3_done_once", done_cnt, 1);

        // T4: zero configuration is rejected
        run_start(16'd5, 16'd0);
        chk("t4_cfg_err", 32'(cfg_err), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_en", 32'(cnt_enable), 0);
        chk("t4_aborted_held", 32'(aborted), 1);
        tick();
        chk("t4_cfg_err_pulse", 32'(cfg_err), 0);
        run_start(16'd0, 16'd5);
        chk("t4_cfg_err_win", 32'(cfg_err), 1);
        tick();

        // T5: run totals saturate in the 16-bit instance
        done_cnt = 0;
        run_start(16'd5, 16'd2);
        chk("t5_aborted_clr", 32'(aborted), 0);
        tick();
        strobe(16'd0, 16'd40000, 16'd0, 1'b0); tick();
        strobe(16'd1, 16'd40000, 16'd0, 1'b0);
        wait_done(n);
        chk("t5_total16", 32'(s_total_pulse), 65535);
        chk("t5_sat16", 32'(s_sat), 1);
        chk("t5_total32", total_pulse, 80000);
        chk("t5_sat32", 32'(sat), 0);
        chk("t5_done_once", done_cnt, 1);

        // T6: reset mid-run, then a fresh run
        run_start(16'd6, 16'd3);
        chk("t6_sat16_clr", 32'(s_sat), 0);
        tick();
        res_ready = 1'b0;
        strobe(16'd0, 16'd3, 16'd1, 1'b0);
        chk("t6_res_valid_pre", 32'(res_valid), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        chk("t6_en_off", 32'(cnt_enable), 0);
        chk("t6_res_valid", 32'(res_valid), 0);
        chk("t6_total_pulse", total_pulse, 0);
        chk("t6_total_pileup", total_pileup, 0);
        chk("t6_busy", 32'(busy), 0);
        res_ready = 1'b1;
        tick();
        done_cnt = 0;
        run_start(16'd9, 16'd1);
        tick();
        strobe(16'd0, 16'd2, 16'd2, 1'b0);
        wait_done(n);
        chk("t6_fresh_pulse", total_pulse, 2);
        chk("t6_fresh_pileup", total_pileup, 2);
        chk("t6_done_once", done_cnt, 1);
        chk("t6_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
